// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM duty generator and its helpers.
package pwm_pkg;

    localparam int unsigned PERIOD_STEPS_DEF = 100;
    localparam int unsigned DUTY_W_DEF       = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } pwm_state_e;

endpackage : pwm_pkg

// File: rtl/edge_tick.sv
// Rising-edge detector for same-clock divider outputs; tick_c is a one-clk pulse.
module edge_tick (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic tick_c
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign tick_c = sig & ~sig_q;

endmodule : edge_tick

// File: rtl/pwm_duty_gen.sv
// PWM generator stepped by divider ticks; duty is double-buffered and applied at period starts.
module pwm_duty_gen
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD_STEPS = PERIOD_STEPS_DEF,
    parameter int unsigned DUTY_W       = DUTY_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freq_in,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              duty_load,
    output logic              pwm_out,
    output logic              period_start,
    output logic [DUTY_W-1:0] duty_active,
    output logic              busy
);

    localparam logic [DUTY_W-1:0] LAST_STEP = DUTY_W'(PERIOD_STEPS - 1);
    localparam logic [DUTY_W-1:0] MAX_DUTY  = DUTY_W'(PERIOD_STEPS);

    pwm_state_e        state, state_nxt;
    logic [DUTY_W-1:0] step_cnt, step_nxt, step_inc;
    logic [DUTY_W-1:0] duty_pend, pend_nxt, duty_clamped;
    logic [DUTY_W-1:0] act_nxt;
    logic              pwm_nxt, ps_nxt, busy_nxt;
    logic              tick;

    edge_tick u_edge_tick (
        .clk    (clk),
        .rst    (rst),
        .sig    (freq_in),
        .tick_c (tick)
    );

    assign duty_clamped = (duty_in > MAX_DUTY) ? MAX_DUTY : duty_in;
    assign step_inc     = step_cnt + DUTY_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath; a same-cycle load bypasses into the period-start transfer.
    always_comb begin
        state_nxt = state;
        step_nxt  = step_cnt;
        pend_nxt  = duty_load ? duty_clamped : duty_pend;
        act_nxt   = duty_active;
        pwm_nxt   = pwm_out;
        ps_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                pwm_nxt  = 1'b0;
                step_nxt = '0;
                if (tick && enable) begin
                    state_nxt = ST_RUN;
                    act_nxt   = pend_nxt;
                    pwm_nxt   = (pend_nxt != '0);
                    ps_nxt    = 1'b1;
                end
            end
            ST_RUN, ST_STOPPING: begin
                state_nxt = enable ? ST_RUN : ST_STOPPING;
                if (tick) begin
                    if (step_cnt == LAST_STEP) begin
                        step_nxt = '0;
                        if (state == ST_RUN || enable) begin
                            act_nxt = pend_nxt;
                            pwm_nxt = (pend_nxt != '0);
                            ps_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                            pwm_nxt   = 1'b0;
                        end
                    end else begin
                        step_nxt = step_inc;
                        pwm_nxt  = (step_inc < duty_active);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                step_nxt  = '0;
                pwm_nxt   = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt     <= '0;
            duty_pend    <= '0;
            duty_active  <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            step_cnt     <= step_nxt;
            duty_pend    <= pend_nxt;
            duty_active  <= act_nxt;
            pwm_out      <= pwm_nxt;
            period_start <= ps_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule : pwm_duty_gen
